// File: rtl/spio_aer2spinn_mapper_pkg.sv
// -----------------------------------------------------------------------------
// spio_aer2spinn_mapper_pkg
//
// Shared SpiNNaker link definitions used by the AER-to-SpiNNaker mapper:
//   - packet width (PKT_BITS, 72 bits = 8-bit control + 32-bit key + 32-bit
//     payload)
//   - control-byte field positions
//   - the multicast packet type code
//   - routing-key bit positions
//   - the packet parity helper and a packet builder
//   - the mapper FSM state encoding
// -----------------------------------------------------------------------------
package spio_aer2spinn_mapper_pkg;

  // Full SpiNNaker link packet width (control + key + payload).
  localparam int PKT_BITS = 72;

  // Control byte layout.
  localparam int CTRL_LSB   = 0;
  localparam int CTRL_MSB   = 7;
  localparam int PARITY_BIT = 0;  // odd parity over the whole packet
  localparam int PLD_BIT    = 1;  // payload present flag
  localparam int TS_LSB     = 2;  // time stamp
  localparam int TS_MSB     = 3;
  localparam int EMG_LSB    = 4;  // emergency routing
  localparam int EMG_MSB    = 5;
  localparam int TYPE_LSB   = 6;  // packet type
  localparam int TYPE_MSB   = 7;

  // Packet type codes.
  localparam logic [1:0] MC_TYPE = 2'b00;

  // Routing-key position inside the packet.
  localparam int KEY_LSB = 8;
  localparam int KEY_MSB = 39;

  // Mapper FSM states. The spare encoding (2'b11) is steered back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  // Parity bit for a payload-less packet: chosen so that the total number of
  // ones across bits [KEY_MSB:0] is odd.
  function automatic logic odd_parity(input logic [KEY_MSB:PARITY_BIT+1] bits);
    return ~^bits;
  endfunction

  // Builds a multicast packet without payload from the two key halves.
  function automatic logic [PKT_BITS-1:0] build_mc_pkt(
    input logic [15:0] key_hi,
    input logic [15:0] key_lo
  );
    logic [PKT_BITS-1:0] pkt;
    pkt                      = '0;
    pkt[TYPE_MSB:TYPE_LSB]   = MC_TYPE;
    pkt[KEY_MSB:KEY_LSB]     = {key_hi, key_lo};
    pkt[PARITY_BIT]          = odd_parity(pkt[KEY_MSB:PARITY_BIT+1]);
    return pkt;
  endfunction

endpackage

// File: rtl/spio_aer2spinn_mapper_sync_bit.sv
// -----------------------------------------------------------------------------
// spio_sync_bit
//
// Multi-flop synchroniser for a single asynchronous control bit. All flops
// reset to 1 so that an active-low request reads as idle straight out of reset.
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous, active-low reset
//   d    in   asynchronous input bit
//   q    out  synchronised bit (SYNC_STAGES clock edges of latency)
//
// Parameters:
//   SYNC_STAGES  number of flops in the chain; values below 2 are raised to 2
// -----------------------------------------------------------------------------
module spio_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // A single flop does not give metastability enough time to resolve.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;

  // Stage 0 takes the raw input; every later stage takes its predecessor.
  assign sync_next[0] = d;
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spio_aer2spinn_mapper.sv
// -----------------------------------------------------------------------------
// spio_aer2spinn_mapper
//
// Converts 16-bit address events arriving over an asynchronous 4-phase AER
// handshake (request and acknowledge both active low) into payload-less
// SpiNNaker multicast packets offered on a valid/ready interface. The routing
// key is {virtual_key, iaer_data}. An optional timeout drops an event whose
// packet is not accepted within DROP_WAIT cycles, so a stalled link cannot
// freeze the AER sender; dropped events are counted in drop_cnt.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   iaer_data    in   [15:0] event address, bundled with iaer_req
//   iaer_req     in   AER request, active low, asynchronous to clk
//   iaer_ack     out  AER acknowledge, active low
//   virtual_key  in   [15:0] upper key half, only changed while idle
//   ipkt_data    out  [PKT_BITS-1:0] packet
//   ipkt_vld     out  packet valid
//   ipkt_rdy     in   packet ready from the link transmitter
//   drop_cnt     out  [15:0] saturating count of dropped events
//
// Parameters:
//   SYNC_STAGES  flops in the iaer_req synchroniser (minimum 2)
//   DROP_WAIT    cycles a packet may wait for ipkt_rdy; 0 disables dropping
// -----------------------------------------------------------------------------
module spio_aer2spinn_mapper
  import spio_aer2spinn_mapper_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DROP_WAIT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         iaer_data,
  input  logic                iaer_req,
  output logic                iaer_ack,
  input  logic [15:0]         virtual_key,
  output logic [PKT_BITS-1:0] ipkt_data,
  output logic                ipkt_vld,
  input  logic                ipkt_rdy,
  output logic [15:0]         drop_cnt
);

  localparam bit DROP_EN  = (DROP_WAIT > 0);
  localparam int TMR_BITS = DROP_EN ? $clog2(DROP_WAIT + 1) : 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(DROP_EN ? DROP_WAIT - 1 : 0);

  logic                req_s;
  state_t              state_reg;
  logic                ack_reg;
  logic                vld_reg;
  logic [PKT_BITS-1:0] data_reg;
  logic [TMR_BITS-1:0] timer_reg;
  logic [15:0]         drop_cnt_reg;

  // Only the request is synchronised. iaer_data is bundled data: the sender
  // keeps it stable while the request is low, so by the time req_s falls the
  // data has long settled and can be sampled directly.
  spio_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (iaer_req),
    .q   (req_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      ack_reg      <= 1'b1;
      vld_reg      <= 1'b0;
      data_reg     <= '0;
      timer_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // A new event is only accepted here, i.e. after the previous
          // acknowledge has returned high, so events are never merged or
          // repeated.
          if (!req_s) begin
            data_reg  <= build_mc_pkt(virtual_key, iaer_data);
            vld_reg   <= 1'b1;
            timer_reg <= '0;
            state_reg <= ST_SEND;
          end
        end

        ST_SEND: begin
          // Packet stays valid and stable until taken; the transfer has
          // priority over a timeout that expires in the same cycle.
          if (ipkt_rdy) begin
            vld_reg   <= 1'b0;
            ack_reg   <= 1'b0;
            state_reg <= ST_ACK;
          end else if (DROP_EN && (timer_reg == TMR_LAST)) begin
            vld_reg   <= 1'b0;
            ack_reg   <= 1'b0;
            state_reg <= ST_ACK;
            if (drop_cnt_reg != 16'hFFFF) begin
              drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
          end else if (DROP_EN) begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_ACK: begin
          // Sender releases the request once it has seen the acknowledge.
          if (req_s) begin
            ack_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b1;
          vld_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign iaer_ack  = ack_reg;
  assign ipkt_vld  = vld_reg;
  assign ipkt_data = data_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_spio_aer2spinn_mapper.sv
// -----------------------------------------------------------------------------
// tb_spio_aer2spinn_mapper
//
// Directed bench for the AER-to-SpiNNaker mapper. Two instances share clock,
// reset, event data and virtual key: u_dut0 has dropping disabled, u_dut8
// drops after 8 cycles. Inputs are driven and outputs sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_spio_aer2spinn_mapper;

  logic        clk;
  logic        rst;
  logic [15:0] iaer_data;
  logic [15:0] virtual_key;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic [71:0] pdata [2];
  logic [15:0] dcnt  [2];

  int checks = 0;
  int errors = 0;

  spio_aer2spinn_mapper #(
    .SYNC_STAGES (2),
    .DROP_WAIT   (0)
  ) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .iaer_data   (iaer_data),
    .iaer_req    (req[0]),
    .iaer_ack    (ack[0]),
    .virtual_key (virtual_key),
    .ipkt_data   (pdata[0]),
    .ipkt_vld    (vld[0]),
    .ipkt_rdy    (rdy[0]),
    .drop_cnt    (dcnt[0])
  );

  spio_aer2spinn_mapper #(
    .SYNC_STAGES (2),
    .DROP_WAIT   (8)
  ) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .iaer_data   (iaer_data),
    .iaer_req    (req[1]),
    .iaer_ack    (ack[1]),
    .virtual_key (virtual_key),
    .ipkt_data   (pdata[1]),
    .ipkt_vld    (vld[1]),
    .ipkt_rdy    (rdy[1]),
    .drop_cnt    (dcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a few thousand cycles long.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference packet: key in [39:8], control byte zero except the parity bit,
  // which makes the count of ones in [39:0] odd.
  function automatic logic [71:0] exp_pkt(input logic [15:0] key, input logic [15:0] ev);
    logic [71:0] p;
    int ones;
    p = '0;
    p[39:8] = {key, ev};
    ones = $countones(p[39:8]);
    p[0] = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return p;
  endfunction

  // One complete handshake that ends in a transfer after 'stall' cycles of
  // rdy low; 'gap' idle cycles elapse before the sender releases req.
  task automatic run_event(input int i, input logic [15:0] key, input logic [15:0] ev,
                           input int stall, input int gap, input logic [71:0] exp,
                           input string tag);
    int n;
    virtual_key = key;
    iaer_data   = ev;
    rdy[i]      = 1'b0;
    req[i]      = 1'b0;
    n = 0;
    while (vld[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_vld_lat"}, 72'(n), 72'd3);
    check({tag, "_data"}, pdata[i], exp);
    check({tag, "_ack_hi"}, 72'(ack[i]), 72'd1);
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_hold_vld"}, 72'(vld[i]), 72'd1);
      check({tag, "_hold_data"}, pdata[i], exp);
      check({tag, "_hold_ack"}, 72'(ack[i]), 72'd1);
    end
    rdy[i] = 1'b1;
    tick();
    rdy[i] = 1'b0;
    check({tag, "_vld_lo"}, 72'(vld[i]), 72'd0);
    check({tag, "_ack_lo"}, 72'(ack[i]), 72'd0);
    for (int g = 0; g < gap; g++) tick();
    req[i] = 1'b1;
    n = 0;
    while (ack[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ack_lat"}, 72'(n), 72'd3);
  endtask

  // One handshake where rdy never arrives and the event is dropped.
  task automatic run_drop(input int i, input logic [15:0] ev, input logic [71:0] exp,
                          input logic [15:0] exp_cnt, input string tag);
    int n;
    iaer_data = ev;
    rdy[i]    = 1'b0;
    req[i]    = 1'b0;
    n = 0;
    while (vld[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_vld_lat"}, 72'(n), 72'd3);
    check({tag, "_data"}, pdata[i], exp);
    n = 0;
    while (vld[i] === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 72'(n), 72'd8);
    check({tag, "_ack_lo"}, 72'(ack[i]), 72'd0);
    check({tag, "_drop_cnt"}, 72'(dcnt[i]), 72'(exp_cnt));
    req[i] = 1'b1;
    n = 0;
    while (ack[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ack_lat"}, 72'(n), 72'd3);
  endtask

  initial begin
    logic [15:0] key;
    logic [15:0] ev;
    logic [15:0] keys [4];
    int n;
    keys[0] = 16'h0200;
    keys[1] = 16'hABCD;
    keys[2] = 16'h0000;
    keys[3] = 16'hFFFF;

    rst         = 1'b0;
    req         = 2'b11;
    rdy         = 2'b00;
    iaer_data   = 16'h0000;
    virtual_key = 16'h0200;
    tick();
    tick();

    // Reset state.
    check("rst_ack0",  72'(ack[0]), 72'd1);
    check("rst_vld0",  72'(vld[0]), 72'd0);
    check("rst_data0", pdata[0],   72'h0);
    check("rst_drop0", 72'(dcnt[0]), 72'd0);
    check("rst_ack8",  72'(ack[1]), 72'd1);
    check("rst_vld8",  72'(vld[1]), 72'd0);
    rst = 1'b1;
    tick();
    tick();

    // Basic events: odd and even key weight.
    run_event(0, 16'h0200, 16'h0001, 0, 0, 72'h0200000101, "ev1");
    $display("event key=0200 ev=0001 done");
    run_event(0, 16'h0200, 16'h0003, 0, 1, 72'h0200000300, "ev3");
    $display("event key=0200 ev=0003 done");

    // Long stall without dropping.
    run_event(0, 16'h0200, 16'h1234, 20, 2, 72'h0200123401, "stall20");
    check("stall20_drop_cnt", 72'(dcnt[0]), 72'd0);
    $display("event key=0200 ev=1234 stall=20 done");

    // Timeout drop.
    virtual_key = 16'h0200;
    run_drop(1, 16'h00FF, 72'h020000FF00, 16'd1, "drop1");
    $display("drop ev=00FF done");

    // rdy arriving on the last allowed cycle wins over the timeout.
    run_event(1, 16'h0200, 16'h0001, 7, 0, 72'h0200000101, "edge8");
    check("edge8_drop_cnt", 72'(dcnt[1]), 72'd1);
    $display("edge-of-timeout transfer done");

    // Saturation: preload near the top, then drop twice.
    force u_dut8.drop_cnt_reg = 16'hFFFE;
    tick();
    release u_dut8.drop_cnt_reg;
    tick();
    check("sat_preload", 72'(dcnt[1]), 72'h0FFFE);
    run_drop(1, 16'h0003, 72'h0200000300, 16'hFFFF, "sat1");
    run_drop(1, 16'h0001, 72'h0200000101, 16'hFFFF, "sat2");
    $display("drop saturation done");

    // 100 back-to-back events with random stalls and sender delays.
    for (int k = 0; k < 100; k++) begin
      key = keys[$urandom_range(0, 3)];
      ev  = 16'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      run_event(0, key, ev, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                exp_pkt(key, ev), "rand");
      $display("rand event %0d key=%h ev=%h done", k, key, ev);
    end
    check("rand_drop_cnt", 72'(dcnt[0]), 72'd0);

    // Reset in the middle of SEND.
    virtual_key = 16'h0200;
    iaer_data   = 16'h0077;
    rdy[0]      = 1'b0;
    req[0]      = 1'b0;
    n = 0;
    while (vld[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("mid_rst_vld_before", 72'(vld[0]), 72'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_vld", 72'(vld[0]), 72'd0);
    check("mid_rst_ack", 72'(ack[0]), 72'd1);
    check("mid_rst_data", pdata[0], 72'h0);
    check("mid_rst_drop8", 72'(dcnt[1]), 72'd0);
    tick();
    req[0] = 1'b1;
    rst    = 1'b1;
    tick();
    $display("reset during SEND done");
    run_event(0, 16'h0200, 16'h0055, 1, 0, 72'h0200005500, "post_rst");
    $display("event key=0200 ev=0055 after reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spio_aer2spinn_mapper.md
Name: spio_aer2spinn_mapper

Overview:
Receives 16-bit address events from an external AER sender over an asynchronous 4-phase handshake. Request and acknowledge are both active low. Each event becomes a SpiNNaker multicast packet without payload, and the packet is offered on the valid/ready packet interface toward the SpiNNaker link transmitter. This block is the input-direction counterpart of the SpiNNaker-to-AER output mapper. It also provides an optional drop-on-timeout path, so that a stalled SpiNNaker link cannot freeze the AER sender.

Parameters:
SYNC_STAGES, 2, number of flops in the iaer_req synchroniser (minimum 2).
DROP_WAIT, 0, number of cycles a packet may wait for ipkt_rdy before the event is dropped; 0 disables dropping.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  asynchronous, active-low reset.
iaer_data  in  16  AER event address; bundled data, must be stable while iaer_req is low.
iaer_req  in  1  AER request, active low, asynchronous to clk.
iaer_ack  out  1  AER acknowledge, active low.
virtual_key  in  16  upper routing-key half; quasi-static, changed only while idle.
ipkt_data  out  PKT_BITS  SpiNNaker packet.
ipkt_vld  out  1  packet valid.
ipkt_rdy  in  1  packet ready from the link transmitter.
drop_cnt  out  16  saturating count of dropped events.

Behaviour:
- Reset (rst low, asynchronous):
  - iaer_ack=1, ipkt_vld=0, ipkt_data=0, drop_cnt=0.
  - Synchroniser flops = 1; state = IDLE; wait timer = 0.
- req_s is iaer_req after SYNC_STAGES flops; all FSM decisions use req_s only. iaer_data is not synchronised; it is sampled directly.
- Packet format:
  - [7:6]=00 (multicast); [5:2]=0000; [1]=0 (no payload).
  - [39:8] = {virtual_key, iaer_data}; [PKT_BITS-1:40] = 0.
  - [0] = odd parity: ~^ipkt_data[39:1], so the total number of ones in [39:0] is odd.
- State IDLE:
  - If req_s==0: latch iaer_data and virtual_key into ipkt_data with parity, set ipkt_vld<=1, clear the timer, go to SEND.
  - Otherwise hold.
- State SEND:
  - ipkt_vld and ipkt_data are held stable.
  - If ipkt_rdy==1: the transfer completes this cycle. Set ipkt_vld<=0, iaer_ack<=0, go to ACK.
  - Else if DROP_WAIT!=0 and timer==DROP_WAIT-1: set ipkt_vld<=0, iaer_ack<=0, drop_cnt<=drop_cnt+1 (saturating at 0xFFFF), go to ACK.
  - Else: timer<=timer+1.
  - The timer width is clog2(DROP_WAIT+1), minimum 1.
- State ACK:
  - If req_s==1: iaer_ack<=1, go to IDLE.
  - Otherwise hold iaer_ack=0.
- Latency:
  - iaer_req falling edge to ipkt_vld high: SYNC_STAGES+1 clk edges.
  - Transfer cycle (vld & rdy) to iaer_ack low: 1 cycle.
  - req_s high to iaer_ack high: 1 cycle.
- Back-to-back events: a new req_s low is honoured only in IDLE, i.e. after iaer_ack has returned high. This guarantees that no event is lost or duplicated.
- ipkt_rdy asserted while not in SEND: ignored.
- ipkt_rdy dropping during SEND: the packet is held; there is no retraction.
- Drop timeout and ipkt_rdy in the same cycle: the transfer wins and drop_cnt is not incremented.
- iaer_req glitch shorter than a clock period: may or may not be seen. If seen, the event is processed normally; the sender is responsible for holding req until ack.
- Reset mid-operation: everything returns to reset values, including an abandoned ipkt_vld and an abandoned iaer_ack=0. The AER sender then sees ack high and completes its cycle.
- Unused FSM encodings go to IDLE.

Decomposition:
- Shared header spio_spinnaker_link.h already defines PKT_BITS.
- Add to that header:
  - control-byte field positions;
  - the multicast type code (2'b00);
  - the key LSB/MSB positions (8/39);
  - a parity helper macro or function.
- One sub-module: spio_sync_bit. It is a SYNC_STAGES-deep synchroniser with a reset value of 1 and the same rst polarity. The mapper instantiates it for iaer_req.

Test Plan:
- virtual_key=0x0200, event 0x0001, ipkt_rdy=1 -> ipkt_data=0x0200000101 (parity 1), vld 3 cycles after req falls, ack low 1 cycle after transfer, ack high 1 cycle after req_s high.
- Event 0x0003 with the same key -> ipkt_data=0x0200000300 (parity 0).
- ipkt_rdy held low for 20 cycles, DROP_WAIT=0 -> vld held and data stable for 20 cycles, ack stays high; rdy=1 then completes normally; drop_cnt=0.
- DROP_WAIT=8, ipkt_rdy=0 permanently -> vld drops after 8 cycles, drop_cnt=1, ack completes. Then 0xFFFF further drops -> drop_cnt stays 0xFFFF.
- DROP_WAIT=8, rdy rises exactly on cycle 8 -> packet transferred, drop_cnt unchanged.
- 100 back-to-back events with random sender delays and random rdy stalls -> 100 packets in order with correct keys and parity, no duplicates. Then rst pulsed low in SEND -> vld=0, ack=1 asynchronously, and the next event is handled normally.
